// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and signed-overflow helper for seq_multdiv_alu.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Subtraction is A + ~B + 1, so the effective B sign is inverted.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = b_msb ^ is_sub;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 shift-add) and restoring divide on magnitudes.
// Divider datapath exists only when SEQ_MULTDIV_DIV_EN is defined.
module multdiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             exc
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               neg_q, neg_d;
    logic               go;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     upper;
    logic [2*WIDTH-1:0] prod;

`ifdef SEQ_MULTDIV_DIV_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    logic             div_q, div_d;
    logic             exc_q, exc_d;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] quot;
    assign go = start;
`else
    assign go = start && !is_div;
`endif

    assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
    assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;

    // Mul: acc = {partial sum, multiplier}. Div: acc = {remainder, quotient/dividend}.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        mag_d  = mag_q;
        neg_d  = neg_q;
        done   = 1'b0;
        upper  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
`ifdef SEQ_MULTDIV_DIV_EN
        div_d  = div_q;
        exc_d  = exc_q;
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, mag_q};
`endif
        if (go) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            neg_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            mag_d  = a_mag;
`ifdef SEQ_MULTDIV_DIV_EN
            div_d  = is_div;
            exc_d  = is_div && ((op_b == '0) || (op_a == MIN_VAL && op_b == '1));
            if (is_div) begin
                acc_d = {{WIDTH{1'b0}}, a_mag};
                mag_d = b_mag;
            end
`endif
        end else if (busy_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = {upper, acc_q[WIDTH-1:1]};
`ifdef SEQ_MULTDIV_DIV_EN
            if (div_q) begin
                acc_d = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
`endif
            if (cnt_q == CNT_W'(WIDTH-1)) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
    end

    // Result is taken from the final iteration's next value so the top can register it on done.
    always_comb begin
        prod   = neg_q ? -acc_d : acc_d;
        result = prod[WIDTH-1:0];
        ovf    = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        exc    = 1'b0;
`ifdef SEQ_MULTDIV_DIV_EN
        quot   = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
        if (div_q) begin
            result = (mag_q == '0) ? '0 : quot;
            ovf    = 1'b0;
            exc    = exc_q;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            mag_q  <= '0;
            neg_q  <= 1'b0;
`ifdef SEQ_MULTDIV_DIV_EN
            div_q  <= 1'b0;
            exc_q  <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            mag_q  <= mag_d;
            neg_q  <= neg_d;
`ifdef SEQ_MULTDIV_DIV_EN
            div_q  <= div_d;
            exc_q  <= exc_d;
`endif
        end
    end

endmodule

// File: rtl/seq_multdiv_alu.sv
// Registered ALU with valid/ready handshake and iterative signed mul/div.
// Define SEQ_MULTDIV_DIV_EN to include the divider; otherwise div completes at once with exception.
module seq_multdiv_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow,
    output logic               exception
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d, exc_q, exc_d;
    logic             pend_ne_q, pend_ne_d, pend_lt_q, pend_lt_d;

    logic             accept, is_multi, start;
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             sub_ovf, flag_ne, flag_lt, alu_ovf, alu_exc;
    logic             core_done, core_ovf, core_exc;
    logic [WIDTH-1:0] core_result;

    assign in_ready = (state_q != BUSY);
    assign accept   = in_valid && in_ready;
    assign sum      = data_operandA + data_operandB;
    assign diff     = data_operandA - data_operandB;
    assign sub_ovf  = signed_ovf(data_operandA[WIDTH-1], data_operandB[WIDTH-1], diff[WIDTH-1], 1'b1);
    assign flag_ne  = |diff;
    assign flag_lt  = diff[WIDTH-1] ^ sub_ovf;
`ifdef SEQ_MULTDIV_DIV_EN
    assign is_multi = (ctrl_ALUopcode == OP_MUL) || (ctrl_ALUopcode == OP_DIV);
`else
    assign is_multi = (ctrl_ALUopcode == OP_MUL);
`endif
    assign start    = accept && is_multi;

    multdiv_iter #(.WIDTH(WIDTH)) u_multdiv (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .is_div (ctrl_ALUopcode == OP_DIV),
        .op_a   (data_operandA),
        .op_b   (data_operandB),
        .done   (core_done),
        .result (core_result),
        .ovf    (core_ovf),
        .exc    (core_exc)
    );

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_exc = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = signed_ovf(data_operandA[WIDTH-1], data_operandB[WIDTH-1], sum[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            OP_AND: alu_res = data_operandA & data_operandB;
            OP_OR:  alu_res = data_operandA | data_operandB;
            OP_SLL: alu_res = data_operandA << ctrl_shiftamt;
            OP_SRA: alu_res = $signed(data_operandA) >>> ctrl_shiftamt;
`ifndef SEQ_MULTDIV_DIV_EN
            OP_DIV: alu_exc = 1'b1;
`endif
            default: ;
        endcase
    end

    // Compare flags of a mul/div are captured at acceptance and published at completion.
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        ne_d        = ne_q;
        lt_d        = lt_q;
        ovf_d       = ovf_q;
        exc_d       = exc_q;
        pend_ne_d   = pend_ne_q;
        pend_lt_d   = pend_lt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept && is_multi) begin
                    state_d   = BUSY;
                    pend_ne_d = flag_ne;
                    pend_lt_d = flag_lt;
                end else if (accept) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    ne_d        = flag_ne;
                    lt_d        = flag_lt;
                    ovf_d       = alu_ovf;
                    exc_d       = alu_exc;
                end
            end
            BUSY: begin
                if (core_done) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = core_result;
                    ne_d        = pend_ne_q;
                    lt_d        = pend_lt_q;
                    ovf_d       = core_ovf;
                    exc_d       = core_exc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ne_q        <= 1'b0;
            lt_q        <= 1'b0;
            ovf_q       <= 1'b0;
            exc_q       <= 1'b0;
            pend_ne_q   <= 1'b0;
            pend_lt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ne_q        <= ne_d;
            lt_q        <= lt_d;
            ovf_q       <= ovf_d;
            exc_q       <= exc_d;
            pend_ne_q   <= pend_ne_d;
            pend_lt_q   <= pend_lt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign data_result = result_q;
    assign isNotEqual  = ne_q;
    assign isLessThan  = lt_q;
    assign overflow    = ovf_q;
    assign exception   = exc_q;

endmodule

// File: tb/tb_seq_multdiv_alu.sv
// Self-checking bench for seq_multdiv_alu: directed table, multi-cycle corner sequences, random ops vs model.
module tb_seq_multdiv_alu;

`ifdef SEQ_MULTDIV_DIV_EN
    localparam bit HAS_DIV = 1'b1;
`else
    localparam bit HAS_DIV = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        exc;
        logic        ne;
        logic        lt;
    } out_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        out_t        exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] opa = '0, opb = '0;
    logic [4:0]  opc = '0, sha = '0;
    logic        out_valid;
    logic [31:0] data_result;
    logic        isNotEqual, isLessThan, overflow, exception;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];

    seq_multdiv_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .ctrl_ALUopcode (opc),
        .ctrl_shiftamt  (sha),
        .out_valid      (out_valid),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow),
        .exception      (exception)
    );

    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: plain signed 64-bit arithmetic on the operands.
    function automatic out_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        out_t m;
        longint sa, sb, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m = '0;
        m.ne = (a != b);
        m.lt = (sa < sb);
        case (op)
            5'd0, 5'd1, 5'd6: begin
                t = (op == 5'd0) ? sa + sb : (op == 5'd1) ? sa - sb : sa * sb;
                m.res = t[31:0];
                m.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            5'd2: m.res = a & b;
            5'd3: m.res = a | b;
            5'd4: m.res = a << sh;
            5'd5: m.res = 32'($signed(a) >>> sh);
            5'd7: begin
                m.exc = 1'b1;
                if (HAS_DIV) begin
                    if (b == 32'd0) m.res = '0;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) m.res = a;
                    else begin
                        t = sa / sb;
                        m.res = t[31:0];
                        m.exc = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        return m;
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        return (op == 5'd6 || (HAS_DIV && op == 5'd7)) ? 33 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [31:0] res, input logic ovf,
                           input logic exc, input logic ne, input logic lt);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh;
        v.exp.res = res; v.exp.ovf = ovf; v.exp.exc = exc; v.exp.ne = ne; v.exp.lt = lt;
        tbl.push_back(v);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output out_t got, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        opc = op; opa = a; opb = b; sha = sh;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        opa = $urandom; opb = $urandom; opc = 5'($urandom_range(0, 7)); sha = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        got = {data_result, overflow, exception, isNotEqual, isLessThan};
    endtask

    task automatic check_rec(input string tag, input out_t exp, input int lat_exp,
                             input out_t got, input int lat);
        chk($sformatf("%s latency", tag), 64'(lat), 64'(lat_exp));
        chk($sformatf("%s result", tag), 64'(got.res), 64'(exp.res));
        chk($sformatf("%s overflow", tag), 64'(got.ovf), 64'(exp.ovf));
        chk($sformatf("%s exception", tag), 64'(got.exc), 64'(exp.exc));
        chk($sformatf("%s isNotEqual", tag), 64'(got.ne), 64'(exp.ne));
        chk($sformatf("%s isLessThan", tag), 64'(got.lt), 64'(exp.lt));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'($signed($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        out_t got, exp;
        int   lat, low, seen;

        reset = 1'b1;
        tick();
        tick();
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset data_result", 64'(data_result), 64'd0);
        chk("reset flags", 64'({overflow, exception, isNotEqual, isLessThan}), 64'd0);
        reset = 1'b0;
        tick();

        add_vec(5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1, 0, 1, 0);
        add_vec(5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 0, 0, 1, 1);
        add_vec(5'd1, 32'd5,         32'd5,         5'd0, 32'h0000_0000, 0, 0, 0, 0);
        add_vec(5'd1, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1, 0, 1, 1);
        add_vec(5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 0, 0, 1, 1);
        add_vec(5'd3, 32'h1234_5678, 32'h0F0F_0000, 5'd0, 32'h1F3F_5678, 0, 0, 1, 0);
        add_vec(5'd4, 32'h0000_0001, 32'h0000_0001, 5'd31, 32'h8000_0000, 0, 0, 0, 0);
        add_vec(5'd5, 32'h8000_0000, 32'h0000_0000, 5'd4, 32'hF800_0000, 0, 0, 1, 1);
        add_vec(5'd5, 32'h1234_5678, 32'h1234_5679, 5'd0, 32'h1234_5678, 0, 0, 1, 1);
        add_vec(5'd6, 32'hFFFF_FFFD, 32'h0000_0007, 5'd0, 32'hFFFF_FFEB, 0, 0, 1, 1);
        add_vec(5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0000_0000, 1, 0, 0, 0);
        add_vec(5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 1, 0, 1, 1);
        add_vec(5'd7, 32'hFFFF_FFF9, 32'h0000_0002, 5'd0, HAS_DIV ? 32'hFFFF_FFFD : 32'h0, 0, !HAS_DIV, 1, 1);
        add_vec(5'd7, 32'h0000_0009, 32'h0000_0000, 5'd0, 32'h0000_0000, 0, 1, 1, 0);
        add_vec(5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, HAS_DIV ? 32'h8000_0000 : 32'h0, 0, 1, 1, 1);
        add_vec(5'h1F, 32'd5,        32'd5,         5'd3, 32'h0000_0000, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, got, lat);
            check_rec($sformatf("vec%0d op%0h", i, tbl[i].op), tbl[i].exp, lat_of(tbl[i].op), got, lat);
        end

        // Back-to-back sub then sra, then output hold.
        tick();
        opc = 5'd1; opa = 32'd5; opb = 32'd5; sha = '0; in_valid = 1'b1;
        tick();
        opc = 5'd5; opa = 32'h8000_0000; opb = 32'd0; sha = 5'd4;
        chk("b2b sub out_valid", 64'(out_valid), 64'd1);
        chk("b2b sub result", 64'(data_result), 64'd0);
        chk("b2b sub isNotEqual", 64'(isNotEqual), 64'd0);
        chk("b2b in_ready in DONE", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b sra out_valid", 64'(out_valid), 64'd1);
        chk("b2b sra result", 64'(data_result), 64'hF800_0000);
        tick();
        chk("hold out_valid low", 64'(out_valid), 64'd0);
        chk("hold result", 64'(data_result), 64'hF800_0000);

        // Reset during a multiply aborts it silently.
        opc = 5'd6; opa = 32'hFFFF_FFFD; opb = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("mid-mul in_ready low", 64'(in_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort data_result", 64'(data_result), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("abort no out_valid", 64'(seen), 64'd0);
        issue(5'd0, 32'd2, 32'd3, 5'd0, got, lat);
        check_rec("post-reset add", model(5'd0, 32'd2, 32'd3, 5'd0), 1, got, lat);

        // in_valid held through BUSY with changing inputs; held add accepted on DONE.
        tick();
        opc = 5'd6; opa = 32'hFFFF_FFFD; opb = 32'd7; sha = '0; in_valid = 1'b1;
        tick();
        lat = 1;
        low = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) low++;
            if (lat < 20) begin
                opc = 5'($urandom_range(0, 7)); opa = $urandom; opb = $urandom; sha = 5'($urandom);
            end else begin
                opc = 5'd0; opa = 32'd10; opb = 32'd20; sha = '0;
            end
            tick();
            lat++;
        end
        chk("busy in_ready low cycles", 64'(low), 64'd32);
        chk("busy mul latency", 64'(lat), 64'd33);
        chk("busy mul result", 64'(data_result), 64'hFFFF_FFEB);
        chk("busy mul overflow", 64'(overflow), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("held add out_valid", 64'(out_valid), 64'd1);
        chk("held add result", 64'(data_result), 64'd30);
        tick();

        for (int i = 0; i < 150; i++) begin
            logic [4:0]  rop, rsh;
            logic [31:0] ra, rb;
            rop = 5'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            rsh = 5'($urandom_range(0, 31));
            exp = model(rop, ra, rb, rsh);
            issue(rop, ra, rb, rsh, got, lat);
            check_rec($sformatf("rand%0d op%0d a=%h b=%h sh=%0d", i, rop, ra, rb, rsh),
                      exp, lat_of(rop), got, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multdiv_alu.md
Name: seq_multdiv_alu

Overview:
- Parametrised, registered successor to the project's combinational 32-bit ALU.
- Adds a valid/ready handshake, a registered result and iterative signed multiply and divide.
- Single-cycle ops (add, sub, and, or, sll, sra) complete in 1 cycle; mul/div take WIDTH+1 cycles.
- Sits between the decode stage and the writeback register; stalls issue via in_ready.

Parameters:
- WIDTH, 32, operand/result width in bits (power of 2, 8..64).
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operands and opcode presented
- in_ready  out  1  block can accept an op this cycle
- data_operandA  in  WIDTH  operand A (two's complement)
- data_operandB  in  WIDTH  operand B
- ctrl_ALUopcode  in  5  operation select
- ctrl_shiftamt  in  SHAMT_W  shift amount for sll/sra
- out_valid  out  1  one-cycle pulse: result fields valid
- data_result  out  WIDTH  registered result
- isNotEqual  out  1  A != B for the accepted op
- isLessThan  out  1  signed A < B for the accepted op
- overflow  out  1  signed overflow (add/sub/mul)
- exception  out  1  divide-by-zero or divide overflow

Behaviour:
- Reset: all outputs 0 except in_ready=1; state IDLE. Reset mid-operation aborts the op with no out_valid.
- Opcodes: 00000 add; 00001 sub; 00010 and; 00011 or; 00100 sll; 00101 sra; 00110 mul; 00111 div. Any other opcode returns result 0 with all flags 0, latency 1.
- Accept: an op is accepted on a rising edge where in_valid && in_ready. Operands are captured at acceptance; later input changes are ignored.
- States:
  - IDLE: in_ready=1. A single-cycle op goes to DONE; mul/div goes to BUSY with count=0.
  - BUSY: in_ready=0. One iteration per cycle; when count==WIDTH-1, go to DONE.
  - DONE: out_valid=1 and in_ready=1. Back-to-back acceptance is allowed: acceptance in DONE behaves as in IDLE; otherwise go to IDLE.
- Latency, acceptance edge to out_valid high:
  - single-cycle ops: 1 cycle
  - mul/div: WIDTH+1 cycles
  - throughput: 1 op/cycle for single-cycle ops.
- Output hold: data_result and flags hold their values after out_valid drops, until the next completion.
- Flags isNotEqual / isLessThan:
  - Computed from A-B of the accepted operands for every opcode.
  - isLessThan = sign(A-B) XOR sub-overflow.
- overflow:
  - add/sub: signed carry mismatch.
  - mul: full 2*WIDTH signed product does not sign-extend from bit WIDTH-1.
  - all other ops: 0.
- add/sub: WIDTH-bit wraparound.
- sll: zero fill. sra: sign fill. shiftamt 0 returns A.
- mul: radix-2 shift-add on magnitudes, sign applied at the end. data_result is the low WIDTH bits of the product.
- div:
  - Restoring division on magnitudes, quotient truncated toward zero, remainder discarded.
  - B==0: result 0, exception=1, still full latency.
  - A==most-negative and B==-1: result=most-negative, exception=1.
- Simultaneous in_valid in BUSY: ignored, not queued; the source must hold in_valid until in_ready.

Optional Feature:
- Macro: SEQ_MULTDIV_DIV_EN.
- Defined: divider datapath present; div behaves as above.
- Undefined: no divider logic. Opcode 00111 completes in 1 cycle with result 0 and exception=1. mul is unaffected.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_DIV)
  - state enum (IDLE, BUSY, DONE)
  - a function for the signed-overflow test.
- One natural sub-module, multdiv_iter, implementing the iterative mul/div core:
  - inputs: start, is_div, operands
  - outputs: done, result, ovf, exc
- The top holds the FSM, the single-cycle datapath and the output registers.

Test Plan (WIDTH=32):
- add 0x7FFFFFFF + 1: out_valid 1 cycle after acceptance, result 0x80000000, overflow=1, isLessThan=0, isNotEqual=1.
- sub 5-5 then back-to-back sra 0x80000000 by 4: consecutive out_valid pulses giving result 0 (isNotEqual=0), then 0xF8000000.
- mul -3 * 7: in_ready low 32 cycles, out_valid on the 33rd cycle, result 0xFFFFFFEB, overflow=0. mul 0x10000 * 0x10000 gives result 0, overflow=1.
- div -7 / 2 gives result 0xFFFFFFFD, exception=0. div 9 / 0 gives result 0, exception=1. div 0x80000000 / -1 gives 0x80000000, exception=1.
- reset asserted at cycle 10 of a mul: next cycle in_ready=1 and out_valid never pulses; a following add 2+3 gives 5.
- in_valid held high during BUSY with changing operands: only the original op completes, and the held op is accepted on the DONE cycle.
